// File: rtl/user_timer.sv
// OBI timer peripheral: prescaled 32-bit up-counter with compare match, one-shot/auto-reload, level irq.
// Latency: gnt combinational with req; rvalid/rdata/err/rid registered, exactly 1 cycle after grant.
// Backpressure: none; every request is granted in its request cycle, responses never stall.

package user_timer_pkg;

    typedef struct packed {
        int unsigned DataWidth;
        int unsigned AddrWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam int unsigned SbrDataWidth = 32;
    localparam int unsigned SbrAddrWidth = 32;
    localparam int unsigned SbrIdWidth   = 4;

    localparam obi_cfg_t SbrObiCfg = '{
        DataWidth: SbrDataWidth,
        AddrWidth: SbrAddrWidth,
        IdWidth:   SbrIdWidth
    };

    typedef struct packed {
        logic [SbrAddrWidth-1:0]   addr;
        logic                      we;
        logic [SbrDataWidth/8-1:0] be;
        logic [SbrDataWidth-1:0]   wdata;
        logic [SbrIdWidth-1:0]     aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        sbr_obi_a_chan_t a;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [SbrDataWidth-1:0] rdata;
        logic [SbrIdWidth-1:0]   rid;
        logic                    err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sbr_obi_r_chan_t r;
    } sbr_obi_rsp_t;

endpackage

module user_timer #(
    parameter user_timer_pkg::obi_cfg_t ObiCfg = user_timer_pkg::SbrObiCfg,
    parameter type obi_req_t = user_timer_pkg::sbr_obi_req_t,
    parameter type obi_rsp_t = user_timer_pkg::sbr_obi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    output logic     irq_o
);

    localparam int unsigned DW = ObiCfg.DataWidth;
    localparam int unsigned BW = DW / 8;

    // Register word indices (addr[4:2]); 5..7 are unmapped.
    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_PRESCALE = 3'd1;
    localparam logic [2:0] IDX_COUNT    = 3'd2;
    localparam logic [2:0] IDX_COMPARE  = 3'd3;
    localparam logic [2:0] IDX_STATUS   = 3'd4;

    // Byte-enable merge of write data into an existing register value.
    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_val,
                                              input logic [DW-1:0] wdata,
                                              input logic [BW-1:0] be);
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < int'(BW); b++) begin
            if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

    logic                        r_en;
    logic                        r_oneshot;
    logic                        r_irq_en;
    logic [15:0]                 r_prescale;
    logic [DW-1:0]               r_count;
    logic [DW-1:0]               r_compare;
    logic                        r_pending;
    logic [15:0]                 r_pcnt;

    logic                        r_rvalid;
    logic [DW-1:0]               r_rdata;
    logic                        r_err;
    logic [ObiCfg.IdWidth-1:0]   r_rid;

    logic                        w_req;
    logic                        w_we;
    logic [ObiCfg.AddrWidth-1:0] w_addr;
    logic [BW-1:0]               w_be;
    logic [DW-1:0]               w_wdata;
    logic [2:0]                  w_idx;
    logic                        w_mapped;
    logic                        w_wr;
    logic                        w_wr_ctrl;
    logic                        w_wr_count;
    logic                        w_clr;
    logic                        w_tick;
    logic                        w_match;
    logic [DW-1:0]               w_rd;
    logic                        w_unused;

    assign w_req    = obi_req_i.req;
    assign w_we     = obi_req_i.a.we;
    assign w_addr   = obi_req_i.a.addr;
    assign w_be     = obi_req_i.a.be;
    assign w_wdata  = obi_req_i.a.wdata;
    assign w_idx    = w_addr[4:2];
    assign w_unused = ^{w_addr[ObiCfg.AddrWidth-1:5], w_addr[1:0]};

    assign w_mapped   = (w_idx <= IDX_STATUS);
    assign w_wr       = w_req && w_we && w_mapped;
    // A CTRL or COUNT write only overrides the tick update if it actually writes bytes.
    assign w_wr_ctrl  = w_wr && (w_idx == IDX_CTRL) && w_be[0];
    assign w_wr_count = w_wr && (w_idx == IDX_COUNT) && (|w_be);
    assign w_clr      = w_wr && (w_idx == IDX_STATUS) && w_be[0] && w_wdata[0];

    assign w_tick  = r_en && (r_pcnt == r_prescale);
    assign w_match = w_tick && (r_count == r_compare);

    assign irq_o = r_pending && r_irq_en;

    // Read mux over pre-update register state.
    always_comb begin
        w_rd = '0;
        case (w_idx)
            IDX_CTRL:     w_rd[2:0]  = {r_irq_en, r_oneshot, r_en};
            IDX_PRESCALE: w_rd[15:0] = r_prescale;
            IDX_COUNT:    w_rd       = r_count;
            IDX_COMPARE:  w_rd       = r_compare;
            IDX_STATUS:   w_rd[0]    = r_pending;
            default:      w_rd       = '0;
        endcase
    end

    // Prescaler: free-runs while enabled, wraps on match; PRESCALE writes do not disturb it.
    always_ff @(posedge clk_i) begin
        if (rst_i || !r_en || w_tick) r_pcnt <= '0;
        else                          r_pcnt <= r_pcnt + 16'd1;
    end

    // CTRL: bus write takes priority over the one-shot auto-disable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_en      <= 1'b0;
            r_oneshot <= 1'b0;
            r_irq_en  <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_en      <= w_wdata[0];
            r_oneshot <= w_wdata[1];
            r_irq_en  <= w_wdata[2];
        end else if (w_match && r_oneshot) begin
            r_en      <= 1'b0;
        end
    end

    // PRESCALE and COMPARE: plain byte-enabled bus registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prescale <= '0;
            r_compare  <= '0;
        end else if (w_wr) begin
            if (w_idx == IDX_PRESCALE) begin
                if (w_be[0]) r_prescale[7:0]  <= w_wdata[7:0];
                if (w_be[1]) r_prescale[15:8] <= w_wdata[15:8];
            end
            if (w_idx == IDX_COMPARE) r_compare <= f_merge(r_compare, w_wdata, w_be);
        end
    end

    // COUNT: bus write wins, else reload on match, else increment (natural wrap) on tick.
    always_ff @(posedge clk_i) begin
        if (rst_i)           r_count <= '0;
        else if (w_wr_count) r_count <= f_merge(r_count, w_wdata, w_be);
        else if (w_match)    r_count <= '0;
        else if (w_tick)     r_count <= r_count + 1'b1;
    end

    // STATUS.pending: hardware set beats a same-cycle write-1-to-clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_pending <= 1'b0;
        else       r_pending <= w_match || (r_pending && !w_clr);
    end

    // Response pipeline: one registered beat per granted request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_rid    <= '0;
        end else begin
            r_rvalid <= w_req;
            r_rdata  <= (w_req && !w_we && w_mapped) ? w_rd : '0;
            r_err    <= w_req && !w_mapped;
            r_rid    <= obi_req_i.a.aid;
        end
    end

    // Response drive; reset in the beat cycle also hides the pending rvalid.
    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = w_req;
        obi_rsp_o.rvalid  = r_rvalid && !rst_i;
        obi_rsp_o.r.rdata = r_rdata;
        obi_rsp_o.r.err   = r_err;
        obi_rsp_o.r.rid   = r_rid;
    end

endmodule

// File: doc/user_timer.md
# user_timer

OBI subordinate timer peripheral attached to one port of the user-domain subordinate demultiplexer. It provides a prescaled 32-bit up-counter with a compare match, auto-reload or one-shot mode, and a level interrupt. The interrupt drives one bit of the user domain's external interrupt vector to the core. It gives the user domain its first functional subordinate next to the error subordinate.

## Interface
- `ObiCfg`, default `SbrObiCfg`: OBI configuration. DataWidth is 32.
- `obi_req_t`, default `sbr_obi_req_t`: OBI request struct.
- `obi_rsp_t`, default `sbr_obi_rsp_t`: OBI response struct.
- `clk_i`, input, 1: the single clock.
- `rst_i`, input, 1: reset. Synchronous, active-high.
- `obi_req_i`, input, `obi_req_t`: request from the demux. Fields used: req, a.addr, a.we, a.be, a.wdata, a.aid.
- `obi_rsp_o`, output, `obi_rsp_t`: response. Fields driven: gnt, rvalid, r.rdata, r.rid, r.err. All other fields are 0.
- `irq_o`, output, 1: level interrupt. Equals STATUS.pending & CTRL.irq_en.

## Operation
- Register map. Decode uses addr[4:2]; addr[1:0] and the upper bits are ignored.
  - 0x00 CTRL: bit0 `en`, bit1 `oneshot`, bit2 `irq_en`. All other bits read 0.
  - 0x04 PRESCALE: bits [15:0]. Upper bits read 0.
  - 0x08 COUNT: [31:0], read/write.
  - 0x0C COMPARE: [31:0], read/write.
  - 0x10 STATUS: bit0 `pending`, write-1-to-clear.
  - 0x14–0x1C: unmapped.
- Bus access rules:
  - Writes honour `be` per byte. `be`=0 writes nothing but still gets a normal response.
  - Unmapped access: no state change, r.err=1, rdata=0.
  - Mapped access: r.err=0. Write responses return rdata=0.
- Prescaler (internal 16-bit `pcnt`):
  - While `en`=0, `pcnt` is held at 0.
  - While `en`=1: if `pcnt`==PRESCALE, a `tick` fires and `pcnt` goes to 0; otherwise `pcnt` increments.
  - Tick period is PRESCALE+1 cycles. PRESCALE=0 gives a tick every cycle.
- Counter, on each `tick`:
  - If COUNT==COMPARE: COUNT goes to 0 and `pending` is set. If `oneshot`=1, `en` is also cleared.
  - Otherwise COUNT increments, wrapping 0xFFFFFFFF to 0 without setting `pending`.
- Simultaneous events:
  - A bus write to COUNT or CTRL wins over the tick update in the same cycle.
  - A hardware set of `pending` wins over a W1C in the same cycle.
  - A PRESCALE write does not reset `pcnt`. If `pcnt` is already above the new PRESCALE, it counts up and wraps through 0xFFFF before matching.
- Reset values: all registers, `pcnt` and `pending` are 0; `irq_o`=0, rvalid=0, gnt follows req.

## Timing
- `gnt` = `req`, combinational. Every request is accepted in its request cycle.
- Response timing:
  - rvalid is asserted exactly 1 cycle after each accepted request, for 1 cycle.
  - r.rid is the registered `aid`; rdata and err are registered in the same cycle.
  - Back-to-back requests on consecutive cycles give back-to-back rvalid. There is no stall.
- Reads sample register state in the grant cycle, before that cycle's updates.
  - Consequence: a read of COUNT returns the pre-tick value.
- Write visibility:
  - Writes take effect at the clock edge ending the grant cycle.
  - A write setting `en` makes the first tick occur PRESCALE+1 cycles later.
- `irq_o` is a function of registers only, so it rises 1 cycle after the matching tick cycle.
- Reset mid-transaction: asserting `rst_i` in the cycle after a grant suppresses that rvalid.

## Test plan
- Reset: hold `rst_i` high 2 cycles with req=0, then read all 5 registers → every read returns 0; `irq_o`=0; each rvalid comes 1 cycle after gnt, with r.rid equal to the issued aid.
- Periodic interrupt:
  - Stimulus: write PRESCALE=3, COMPARE=4, CTRL=0x5.
  - Required: `pending` sets 20 cycles after the CTRL write completes; `irq_o` rises the next cycle; COUNT reads 0 afterwards and keeps counting.
  - Required: W1C of STATUS=1 drops `irq_o` in the next cycle.
- One-shot:
  - Stimulus: write PRESCALE=0, COMPARE=2, CTRL=0x3.
  - Required: after the match, CTRL reads 0x2, COUNT stays 0, `pending`=1, `irq_o`=0 because `irq_en`=0.
- Wrap and partial writes:
  - Stimulus: with `en`=0, write COUNT=0xFFFFFFFE and COMPARE=5, then enable with PRESCALE=0.
  - Required: COUNT passes through 0xFFFFFFFF and 0 without setting `pending`.
  - Stimulus: write COMPARE with be=0b0010 and wdata=0xAABBCCDD.
  - Required: COMPARE reads 0x0000CC05.
- Error and collisions:
  - Stimulus: read 0x18 → required: err=1, rdata=0.
  - Stimulus: in the cycle where a tick hits the match, issue a W1C of STATUS → required: `pending` stays 1.
  - Stimulus: write COUNT=0x100 in a tick cycle → required: COUNT reads 0x100.
